// File: rtl/cache_defs.sv
// Shared data-cache definitions: geometry constants and the write-back/victim
// controller state encoding.
package cache_defs;

  localparam int unsigned DCACHE_IDX_BITS   = 6;
  localparam int unsigned DCACHE_REPLAY_MAX = 2;
  localparam int unsigned DCACHE_REPLAY_W   = 2;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_LOOKUP      = 4'd1,
    ST_WRITEBACK   = 4'd2,
    ST_CLEAN       = 4'd3,
    ST_ALLOCATE    = 4'd4,
    ST_FILL        = 4'd5,
    ST_FLUSH_RD    = 4'd6,
    ST_FLUSH_CHK   = 4'd7,
    ST_FLUSH_WRB   = 4'd8,
    ST_FLUSH_CLEAN = 4'd9,
    ST_FLUSH_DONE  = 4'd10
  } dcache_state_e;

endpackage

// File: rtl/wb_dcache_vc_controller.sv
// Write-back data cache controller with victim-cache swap and full-cache flush.
// Decisions are Mealy on the LOOKUP cycle, where RAM read data and status are valid.
module wb_dcache_vc_controller
  import cache_defs::*;
#(
  parameter int unsigned IDX_BITS = DCACHE_IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lsummu2dcache_req_i,
  input  logic                lsummu2dcache_wr_i,
  input  logic                dcache_flush_i,
  output logic                dcache2lsummu_ack_o,
  output logic                dcache_flush_ack_o,
  input  logic                cache_hit_i,
  input  logic                cache_evict_req_i,
  input  logic                dcache_valid_i,
  input  logic                victim_hit_i,
  output logic                datapath_req_o,
  output logic                cache_wr_o,
  output logic                cache_line_wr_o,
  output logic                cache_line_clean_o,
  output logic                cache_wrb_req_o,
  output logic                write_to_victim_o,
  output logic                write_from_victim_o,
  output logic                lsu_victim_mux_sel_o,
  output logic [IDX_BITS-1:0] evict_index_o,
  output logic                dcache2mem_req_o,
  output logic                dcache2mem_wr_o,
  input  logic                mem2dcache_ack_i
);

  dcache_state_e              r_state;
  dcache_state_e              w_state_nxt;
  logic [IDX_BITS-1:0]        r_idx;
  logic [IDX_BITS-1:0]        w_idx_nxt;
  logic [DCACHE_REPLAY_W-1:0] r_replay;
  logic [DCACHE_REPLAY_W-1:0] w_replay_nxt;
  logic                       r_xfer;
  logic                       w_xfer_nxt;

  logic w_dirty;
  logic w_stuck;
  logic w_do_wb;
  logic w_do_swap;
  logic w_idx_last;

  // LOOKUP decode: dirty check first, then victim swap; one transfer per request.
  // A request that still misses after its replays (or would need a second
  // writeback) is abandoned with an ack rather than looping forever.
  assign w_dirty    = dcache_valid_i & cache_evict_req_i;
  assign w_stuck    = ~cache_hit_i &
                      ((r_replay == DCACHE_REPLAY_W'(DCACHE_REPLAY_MAX)) | (w_dirty & r_xfer));
  assign w_do_wb    = ~cache_hit_i & ~w_stuck & w_dirty;
  assign w_do_swap  = ~cache_hit_i & ~w_stuck & ~w_dirty & victim_hit_i & ~r_xfer;
  assign w_idx_last = (r_idx == {IDX_BITS{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_replay <= '0;
      r_xfer   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_replay <= w_replay_nxt;
      r_xfer   <= w_xfer_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_replay_nxt = r_replay;
    w_xfer_nxt   = r_xfer;
    case (r_state)
      ST_IDLE: begin
        w_replay_nxt = '0;
        w_xfer_nxt   = 1'b0;
        if (dcache_flush_i)           w_state_nxt = ST_FLUSH_RD;
        else if (lsummu2dcache_req_i) w_state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (cache_hit_i || w_stuck) begin
          w_state_nxt = ST_IDLE;
        end else if (w_do_wb) begin
          w_state_nxt = ST_WRITEBACK;
          w_xfer_nxt  = 1'b1;
        end else if (w_do_swap) begin
          w_xfer_nxt = 1'b1;
          if (lsummu2dcache_wr_i) begin
            w_state_nxt  = ST_LOOKUP;
            w_replay_nxt = r_replay + DCACHE_REPLAY_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: if (mem2dcache_ack_i) w_state_nxt = ST_CLEAN;
      ST_CLEAN: begin
        w_state_nxt  = ST_LOOKUP;
        w_replay_nxt = r_replay + DCACHE_REPLAY_W'(1);
      end
      ST_ALLOCATE: if (mem2dcache_ack_i) w_state_nxt = ST_FILL;
      ST_FILL: begin
        w_state_nxt  = ST_LOOKUP;
        w_replay_nxt = r_replay + DCACHE_REPLAY_W'(1);
      end
      ST_FLUSH_RD: w_state_nxt = ST_FLUSH_CHK;
      ST_FLUSH_CHK: begin
        if (w_dirty)         w_state_nxt = ST_FLUSH_WRB;
        else if (w_idx_last) w_state_nxt = ST_FLUSH_DONE;
        else begin
          w_state_nxt = ST_FLUSH_RD;
          w_idx_nxt   = r_idx + IDX_BITS'(1);
        end
      end
      ST_FLUSH_WRB: if (mem2dcache_ack_i) w_state_nxt = ST_FLUSH_CLEAN;
      ST_FLUSH_CLEAN: begin
        if (w_idx_last) w_state_nxt = ST_FLUSH_DONE;
        else begin
          w_state_nxt = ST_FLUSH_RD;
          w_idx_nxt   = r_idx + IDX_BITS'(1);
        end
      end
      ST_FLUSH_DONE: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Mealy outputs; forced low while reset is held so memory never sees a request.
  always_comb begin
    dcache2lsummu_ack_o  = 1'b0;
    dcache_flush_ack_o   = 1'b0;
    datapath_req_o       = 1'b0;
    cache_wr_o           = 1'b0;
    cache_line_wr_o      = 1'b0;
    cache_line_clean_o   = 1'b0;
    cache_wrb_req_o      = 1'b0;
    write_to_victim_o    = 1'b0;
    write_from_victim_o  = 1'b0;
    lsu_victim_mux_sel_o = 1'b0;
    evict_index_o        = '0;
    dcache2mem_req_o     = 1'b0;
    dcache2mem_wr_o      = 1'b0;
    if (rst_n) begin
      evict_index_o = r_idx;
      case (r_state)
        ST_IDLE: datapath_req_o = dcache_flush_i | lsummu2dcache_req_i;
        ST_LOOKUP: begin
          if (cache_hit_i || w_stuck) begin
            dcache2lsummu_ack_o = 1'b1;
            cache_wr_o          = cache_hit_i & lsummu2dcache_wr_i;
          end else if (w_do_swap) begin
            write_from_victim_o = 1'b1;
            write_to_victim_o   = dcache_valid_i;
            if (lsummu2dcache_wr_i) begin
              datapath_req_o = 1'b1;
            end else begin
              lsu_victim_mux_sel_o = 1'b1;
              dcache2lsummu_ack_o  = 1'b1;
            end
          end else if (!w_do_wb) begin
            write_to_victim_o = dcache_valid_i;
          end
        end
        ST_WRITEBACK, ST_FLUSH_WRB: begin
          cache_wrb_req_o  = 1'b1;
          dcache2mem_req_o = 1'b1;
          dcache2mem_wr_o  = 1'b1;
        end
        ST_CLEAN: begin
          cache_line_clean_o = 1'b1;
          datapath_req_o     = 1'b1;
        end
        ST_ALLOCATE:    dcache2mem_req_o   = 1'b1;
        ST_FILL:        cache_line_wr_o    = 1'b1;
        ST_FLUSH_RD:    datapath_req_o     = 1'b1;
        ST_FLUSH_CLEAN: cache_line_clean_o = 1'b1;
        ST_FLUSH_DONE:  dcache_flush_ack_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
